// File: rtl/sample_frame_controller_if.sv
// Consumer-side frame handoff bus: held-frame valid/ack handshake plus the frame read port.
interface sample_frame_controller_if #(
  parameter int WIDTH = 12,
  parameter int N     = 256
);
  logic                 frame_valid;
  logic                 frame_bank;
  logic                 frame_ack;
  logic [$clog2(N)-1:0] rd_addr;
  logic [WIDTH-1:0]     rd_data;

  modport master (
    output frame_valid, frame_bank, rd_data,
    input  frame_ack, rd_addr
  );

  modport slave (
    input  frame_valid, frame_bank, rd_data,
    output frame_ack, rd_addr
  );
endinterface

// File: rtl/sample_frame_controller.sv
// Captures ADC samples at the strobe rate into a ping-pong frame buffer and hands
// completed frames to the FFT reader; frames that find no free bank are dropped and counted.
module sample_frame_controller #(
  parameter int WIDTH       = 12,
  parameter int N           = 256,
  parameter int CLK_HZ      = 10000000,
  parameter int SAMPLE_RATE = 5000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          adc_sample,
  output logic                      sample_tick,
  output logic [7:0]                overrun_count,
  output logic                      capturing,
  sample_frame_controller_if.master frame_bus
);
  localparam int DIV   = CLK_HZ / SAMPLE_RATE;
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_count;
  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [WIDTH-1:0] frame_mem [2*N];
  logic             wr_en;
  logic             bank_free;

  // A tick coinciding with the cycle capture is dropped is discarded along with the partial frame.
  always_comb begin
    wr_en     = rst && (state == CAPTURE) && enable && sample_tick;
    bank_free = !frame_bus.frame_valid || frame_bus.frame_ack;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      frame_mem[{wr_bank, wr_idx}] <= adc_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                 <= IDLE;
      tick_count            <= '0;
      wr_bank               <= 1'b0;
      wr_idx                <= '0;
      sample_tick           <= 1'b0;
      capturing             <= 1'b0;
      overrun_count         <= 8'd0;
      frame_bus.frame_valid <= 1'b0;
      frame_bus.frame_bank  <= 1'b0;
      frame_bus.rd_data     <= '0;
    end else begin
      frame_bus.rd_data <= frame_mem[{frame_bus.frame_bank, frame_bus.rd_addr}];
      if (frame_bus.frame_valid && frame_bus.frame_ack) begin
        frame_bus.frame_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= CAPTURE;
            capturing <= 1'b1;
          end
        end
        CAPTURE: begin
          if (!enable) begin
            state       <= IDLE;
            capturing   <= 1'b0;
            tick_count  <= '0;
            sample_tick <= 1'b0;
            wr_idx      <= '0;
          end else begin
            tick_count  <= (tick_count == CNT_LAST) ? '0 : tick_count + 1'b1;
            sample_tick <= (tick_count == CNT_PRE);
            if (wr_en) begin
              if (wr_idx != IDX_LAST) begin
                wr_idx <= wr_idx + 1'b1;
              end else begin
                wr_idx <= '0;
                // A same-cycle ack frees the held bank, so the new frame is published instead of dropped.
                if (bank_free) begin
                  frame_bus.frame_valid <= 1'b1;
                  frame_bus.frame_bank  <= wr_bank;
                  wr_bank               <= !wr_bank;
                end else if (overrun_count != 8'hFF) begin
                  overrun_count <= overrun_count + 8'd1;
                end
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sample_frame_controller.sv
// Randomized and directed checks of sample_frame_controller against a frame-level reference model.
module tb_sample_frame_controller;
  localparam int WIDTH       = 12;
  localparam int N           = 8;
  localparam int CLK_HZ      = 40;
  localparam int SAMPLE_RATE = 10;
  localparam int DIV         = CLK_HZ / SAMPLE_RATE;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] adc_sample = '0;
  logic             sample_tick;
  logic [7:0]       overrun_count;
  logic             capturing;

  sample_frame_controller_if #(.WIDTH(WIDTH), .N(N)) frame_bus ();

  sample_frame_controller #(
    .WIDTH(WIDTH), .N(N), .CLK_HZ(CLK_HZ), .SAMPLE_RATE(SAMPLE_RATE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .adc_sample(adc_sample),
    .sample_tick(sample_tick),
    .overrun_count(overrun_count),
    .capturing(capturing),
    .frame_bus(frame_bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model: cycles since capture began, the current partial frame as a queue,
  // and the two banks as plain arrays.
  bit mCapture;
  int mCycle;
  int mFrame[$];
  bit mWrBank;
  bit mValid;
  bit mBank;
  int mOverruns;
  int mMem[2][N];
  bit mWritten[2][N];
  int mRdData;
  bit mRdKnown;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep();
    bit tick;
    bit free;
    if (!rst) begin
      mCapture  = 0;
      mCycle    = 0;
      mFrame.delete();
      mWrBank   = 0;
      mValid    = 0;
      mBank     = 0;
      mOverruns = 0;
      mRdData   = 0;
      mRdKnown  = 1;
      return;
    end
    mRdKnown = mWritten[mBank][frame_bus.rd_addr];
    mRdData  = mMem[mBank][frame_bus.rd_addr];
    tick = mCapture && enable && (mCycle % DIV == DIV - 1);
    free = !mValid || frame_bus.frame_ack;
    if (mValid && frame_bus.frame_ack) mValid = 0;
    if (tick) begin
      mMem[mWrBank][mFrame.size()]     = int'(adc_sample);
      mWritten[mWrBank][mFrame.size()] = 1;
      mFrame.push_back(int'(adc_sample));
      if (mFrame.size() == N) begin
        mFrame.delete();
        if (free) begin
          mValid  = 1;
          mBank   = mWrBank;
          mWrBank = !mWrBank;
        end else if (mOverruns < 255) begin
          mOverruns++;
        end
      end
    end
    if (!mCapture) begin
      if (enable) begin
        mCapture = 1;
        mCycle   = 0;
      end
    end else if (!enable) begin
      mCapture = 0;
      mCycle   = 0;
      mFrame.delete();
    end else begin
      mCycle++;
    end
  endtask

  task automatic checkAll();
    checkOutput("sample_tick", sample_tick, (mCapture && (mCycle % DIV == DIV - 1)) ? 1 : 0);
    checkOutput("capturing", capturing, mCapture);
    checkOutput("frame_valid", frame_bus.frame_valid, mValid);
    checkOutput("frame_bank", frame_bus.frame_bank, mBank);
    checkOutput("overrun_count", overrun_count, mOverruns);
    if (mRdKnown) checkOutput("rd_data", frame_bus.rd_data, mRdData);
  endtask

  task automatic applyStimulus(input bit en, input bit ack, input logic [2:0] addr, input logic [WIDTH-1:0] sample);
    enable             = en;
    frame_bus.frame_ack = ack;
    frame_bus.rd_addr   = addr;
    adc_sample         = sample;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic pulseReset();
    rst = 0;
    applyStimulus(0, 0, 0, 0);
    rst = 1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks;
    frame_bus.frame_ack = 0;
    frame_bus.rd_addr   = '0;

    rst = 0;
    repeat (2) applyStimulus(0, 0, 0, 0);
    checkOutput("reset_valid", frame_bus.frame_valid, 0);
    checkOutput("reset_rd_data", frame_bus.rd_data, 0);

    // First frame: sample value equals its index, then read it back.
    rst = 1;
    for (int c = 0; c < 4 * N + 1; c++) applyStimulus(1, 0, 0, 12'(mFrame.size()));
    checkOutput("s1_valid", frame_bus.frame_valid, 1);
    checkOutput("s1_bank", frame_bus.frame_bank, 0);
    for (int k = 0; k < N; k++) begin
      applyStimulus(1, 0, 3'(k), 12'(mFrame.size()));
      checkOutput("s1_rd", frame_bus.rd_data, k);
    end

    // Prompt acks: banks alternate 0,1,0.
    pulseReset();
    acks = 0;
    for (int c = 0; c < 3 * 4 * N + 3; c++) begin
      if (mValid) begin
        checkOutput("s2_bank_seq", frame_bus.frame_bank, acks % 2);
        acks++;
      end
      applyStimulus(1, mValid, 0, 12'(mFrame.size()));
    end
    checkOutput("s2_overrun", overrun_count, 0);

    // No acks: first frame stays held, two overruns.
    pulseReset();
    for (int c = 0; c < 3 * 4 * N + 1; c++) applyStimulus(1, 0, 3, 12'(mFrame.size()));
    checkOutput("s3_valid", frame_bus.frame_valid, 1);
    checkOutput("s3_bank", frame_bus.frame_bank, 0);
    checkOutput("s3_overrun", overrun_count, 2);
    checkOutput("s3_rd", frame_bus.rd_data, 3);

    // Ack lands exactly in the tick completing frame 2.
    pulseReset();
    for (int c = 0; c < 4 * N + 1; c++) applyStimulus(1, 0, 0, 12'(mFrame.size()));
    for (int c = 0; c < 4 * N; c++)
      applyStimulus(1, (mFrame.size() == N - 1) && (mCycle % DIV == DIV - 1), 0, 12'(mFrame.size()));
    checkOutput("s4_valid", frame_bus.frame_valid, 1);
    checkOutput("s4_bank", frame_bus.frame_bank, 1);
    checkOutput("s4_overrun", overrun_count, 0);

    // Drop enable mid-frame, re-enable, frame holds only fresh samples.
    pulseReset();
    for (int c = 0; c < 100 && mFrame.size() < 5; c++) applyStimulus(1, 0, 0, 12'(mFrame.size()));
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput("s5_idle", capturing, 0);
    applyStimulus(1, 0, 0, 12'(100 + mFrame.size()));
    checkOutput("s5_capturing", capturing, 1);
    for (int c = 0; c < 4 * N; c++) applyStimulus(1, 0, 0, 12'(100 + mFrame.size()));
    checkOutput("s5_valid", frame_bus.frame_valid, 1);
    for (int k = 0; k < N; k++) begin
      applyStimulus(1, 0, 3'(k), 12'(mFrame.size()));
      checkOutput("s5_rd", frame_bus.rd_data, 100 + k);
    end

    // Saturate the overrun counter, then reset mid-frame.
    pulseReset();
    for (int c = 0; c < 302 * 4 * N + 1; c++) applyStimulus(1, 0, 0, 12'($urandom));
    checkOutput("s6_saturate", overrun_count, 255);
    repeat (10) applyStimulus(1, 0, 0, 12'($urandom));
    rst = 0;
    applyStimulus(1, 0, 0, 0);
    checkOutput("s6_rst_valid", frame_bus.frame_valid, 0);
    checkOutput("s6_rst_overrun", overrun_count, 0);
    checkOutput("s6_rst_capturing", capturing, 0);
    checkOutput("s6_rst_rd", frame_bus.rd_data, 0);
    rst = 1;
    for (int c = 0; c < 4 * N + 1; c++) applyStimulus(1, 0, 0, 12'(mFrame.size()));
    checkOutput("s6_restart_valid", frame_bus.frame_valid, 1);
    checkOutput("s6_restart_bank", frame_bus.frame_bank, 0);

    // Random traffic with occasional resets and enable drops.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0,
                    3'($urandom_range(0, N - 1)), 12'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end
endmodule
